// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes and FSM states.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StCalc  = 2'b01,
    StFixup = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide with HI/LO result registers.
// Signed ops run on magnitudes; signs are reapplied in the FIXUP cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             kill,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam int unsigned AccW = 2 * WIDTH + 1;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [AccW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  // Operand magnitudes; op[0]=0 selects the signed variants.
  logic               rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;

  assign rs_neg = ~op[0] & rs_data[WIDTH-1];
  assign rt_neg = ~op[0] & rt_data[WIDTH-1];
  assign rs_mag = rs_neg ? -rs_data : rs_data;
  assign rt_mag = rt_neg ? -rt_data : rt_data;

  // Shift-add step: add multiplicand into the upper half when the low bit is set, shift right.
  logic [WIDTH:0]     mul_sum;
  logic [AccW-1:0]    mul_next;

  assign mul_sum  = acc_q[AccW-1:WIDTH] + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
  assign mul_next = {1'b0, mul_sum, acc_q[WIDTH-1:1]};

  // Restoring step: shift left, trial-subtract divisor, keep it if no borrow.
  logic [AccW-1:0]    div_sh;
  logic [WIDTH+1:0]   div_diff;
  logic [AccW-1:0]    div_next;

  assign div_sh   = {acc_q[AccW-2:0], 1'b0};
  assign div_diff = {1'b0, div_sh[AccW-1:WIDTH]} - {2'b00, opnd_q};
  assign div_next = div_diff[WIDTH+1] ? div_sh
                                      : {div_diff[WIDTH:0], div_sh[WIDTH-1:1], 1'b1};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_fix = neg_lo_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
  assign quo_fix  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    unique case (state_q)
      StIdle: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          is_div_d = op[1];
          opnd_d   = rt_mag;
          cnt_d    = '0;
          neg_lo_d = rs_neg ^ rt_neg;
          neg_hi_d = op[1] ? rs_neg : (rs_neg ^ rt_neg);
          if (op[1] && (rt_data == '0)) begin
            // Divide by zero bypasses the iterations; raw dividend goes to HI.
            dz_d    = 1'b1;
            acc_d   = {{(WIDTH + 1){1'b0}}, rs_data};
            state_d = StFixup;
          end else begin
            dz_d    = 1'b0;
            acc_d   = {{(WIDTH + 1){1'b0}}, rs_mag};
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFixup;
      end
      StFixup: begin
        done_d  = 1'b1;
        state_d = StIdle;
        if (dz_q) begin
          hi_d       = acc_q[WIDTH-1:0];
          lo_d       = {WIDTH{1'b1}};
          div_zero_d = 1'b1;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = StIdle;
    endcase

    // Kill overrides everything: abandon the op and leave architectural state alone.
    if (kill) begin
      state_d    = StIdle;
      done_d     = 1'b0;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = div_zero_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule
